// File: rtl/grf_scoreboard.sv
// Register file with two write ports, two bypassed read ports and a per-register
// pending scoreboard tracking destinations issued but not yet written back.
module grf_scoreboard #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic [DW-1:0] wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic [DW-1:0] wd1,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_a,
  output logic          busy1,
  output logic          busy2,
  output logic [AW:0]   pend_cnt
);

  localparam int unsigned NREG = 2**AW;

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic            wr0_ok;
  logic            wr1_ok;
  logic            iss_ok;

  // Register 0 is hardwired: nothing ever targets it
  assign wr0_ok = we0 && (wa0 != '0);
  assign wr1_ok = we1 && (wa1 != '0);
  assign iss_ok = iss_en && (iss_a != '0);

  // Writebacks clear pending first so a same-cycle issue to that register wins
  always_comb begin
    pending_nxt = pending;
    if (wr0_ok) pending_nxt[wa0] = 1'b0;
    if (wr1_ok) pending_nxt[wa1] = 1'b0;
    if (iss_ok) pending_nxt[iss_a] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs     <= '{default: '0};
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr0_ok && !(wr1_ok && (wa1 == wa0))) regs[wa0] <= wd0;
      if (wr1_ok) regs[wa1] <= wd1;
      pending  <= pending_nxt;
      pend_cnt <= (AW+1)'($countones(pending_nxt));
    end
  end

  // Read port 1: port-1 write bypass beats port-0 write bypass beats array
  always_comb begin
    rd1   = regs[ra1];
    busy1 = pending[ra1];
    if (we0 && (wa0 == ra1)) begin
      rd1   = wd0;
      busy1 = 1'b0;
    end
    if (we1 && (wa1 == ra1)) begin
      rd1   = wd1;
      busy1 = 1'b0;
    end
    if (ra1 == '0) begin
      rd1   = '0;
      busy1 = 1'b0;
    end
  end

  // Read port 2: same priority as port 1
  always_comb begin
    rd2   = regs[ra2];
    busy2 = pending[ra2];
    if (we0 && (wa0 == ra2)) begin
      rd2   = wd0;
      busy2 = 1'b0;
    end
    if (we1 && (wa1 == ra2)) begin
      rd2   = wd1;
      busy2 = 1'b0;
    end
    if (ra2 == '0) begin
      rd2   = '0;
      busy2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Randomized self-checking bench for grf_scoreboard against an array-based
// model of register contents and outstanding destinations.
module tb_grf_scoreboard;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 2**AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          we0, we1, iss_en;
  logic [AW-1:0] wa0, wa1, ra1, ra2, iss_a;
  logic [DW-1:0] wd0, wd1;
  logic [DW-1:0] rd1, rd2;
  logic          busy1, busy2;
  logic [AW:0]   pend_cnt;

  grf_scoreboard #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .iss_en(iss_en), .iss_a(iss_a),
    .busy1(busy1), .busy2(busy2), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  // Reference state: register values, outstanding set, registered count
  logic [DW-1:0] m_regs [NREG];
  bit            m_pend [NREG];
  int            m_cnt;
  int            n_chk  = 0;
  int            n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra);
    if (ra == 0) return '0;
    if (we1 && wa1 == ra) return wd1;
    if (we0 && wa0 == ra) return wd0;
    return m_regs[ra];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] ra);
    if (ra == 0) return 1'b0;
    if ((we1 && wa1 == ra) || (we0 && wa0 == ra)) return 1'b0;
    return m_pend[ra];
  endfunction

  task automatic cmp_model();
    chk("rd1",      rd1,      exp_rd(ra1));
    chk("rd2",      rd2,      exp_rd(ra2));
    chk("busy1",    busy1,    exp_busy(ra1));
    chk("busy2",    busy2,    exp_busy(ra2));
    chk("pend_cnt", pend_cnt, m_cnt);
  endtask

  // Apply the clock edge to the model using the inputs held this cycle
  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (we0 && wa0 != 0) begin m_regs[wa0] = wd0; m_pend[wa0] = 1'b0; end
      if (we1 && wa1 != 0) begin m_regs[wa1] = wd1; m_pend[wa1] = 1'b0; end
      if (iss_en && iss_a != 0) m_pend[iss_a] = 1'b1;
    end
    m_cnt = 0;
    for (int i = 0; i < NREG; i++) m_cnt += int'(m_pend[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_a = '0; ra1 = '0; ra2 = '0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG-1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    for (int i = 0; i < NREG; i++) begin m_regs[i] = '0; m_pend[i] = 1'b0; end
    m_cnt = 0;
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    tick();

    // Reset state
    idle(); ra1 = 5;
    #4; cmp_model();
    chk("rst_rd1", rd1, 0); chk("rst_busy1", busy1, 0); chk("rst_cnt", pend_cnt, 0);
    tick();

    // Dual write to one address: port 1 wins, bypass and stored
    idle(); we0 = 1; wa0 = 3; wd0 = 'hAAAA; we1 = 1; wa1 = 3; wd1 = 'h5555; ra1 = 3;
    #4; cmp_model(); chk("dual_byp", rd1, 'h5555);
    tick();
    idle(); ra1 = 3;
    #4; cmp_model(); chk("dual_store", rd1, 'h5555);
    tick();

    // Issue, busy, writeback clears
    idle(); iss_en = 1; iss_a = 7; ra2 = 7;
    #4; cmp_model(); chk("iss_same_busy", busy2, 0);
    tick();
    idle(); ra2 = 7;
    #4; cmp_model(); chk("iss_busy", busy2, 1); chk("iss_cnt", pend_cnt, 1);
    tick();
    idle(); we0 = 1; wa0 = 7; wd0 = 'h1234; ra2 = 7;
    #4; cmp_model(); chk("wb_busy", busy2, 0); chk("wb_rd", rd2, 'h1234);
    tick();
    idle(); ra2 = 7;
    #4; cmp_model(); chk("wb_cnt", pend_cnt, 0);
    tick();

    // Re-issue and writeback in the same cycle: issue wins
    idle(); iss_en = 1; iss_a = 7;
    tick();
    idle(); iss_en = 1; iss_a = 7; we1 = 1; wa1 = 7; wd1 = 'h77; ra1 = 7;
    #4; cmp_model(); chk("reiss_byp_busy", busy1, 0);
    tick();
    idle(); ra1 = 7;
    #4; cmp_model(); chk("reiss_busy", busy1, 1); chk("reiss_cnt", pend_cnt, 1);
    tick();
    idle(); we0 = 1; wa0 = 7; wd0 = 'h99;
    tick();

    // Register 0 ignores writes and issues
    idle(); we1 = 1; wa1 = 0; wd1 = 'hFFFF; iss_en = 1; iss_a = 0;
    #4; cmp_model(); chk("r0_rd", rd1, 0); chk("r0_busy", busy1, 0);
    tick();
    idle();
    #4; cmp_model(); chk("r0_cnt", pend_cnt, 0); chk("r0_rd_after", rd2, 0);
    tick();

    // Two writebacks to distinct pending registers plus one new issue
    idle(); iss_en = 1; iss_a = 4;
    tick();
    idle(); iss_en = 1; iss_a = 9;
    tick();
    idle(); ra1 = 9;
    #4; cmp_model(); chk("two_pend_cnt", pend_cnt, 2);
    tick();
    idle(); we0 = 1; wa0 = 4; wd0 = 'h44; we1 = 1; wa1 = 9; wd1 = 'h99; iss_en = 1; iss_a = 12;
    tick();
    idle(); ra1 = 12; ra2 = 4;
    #4; cmp_model();
    chk("multi_cnt", pend_cnt, 1); chk("multi_busy12", busy1, 1); chk("multi_busy4", busy2, 0);
    tick();
    idle(); ra1 = 9;
    #4; cmp_model(); chk("multi_busy9", busy1, 0);
    tick();

    // Reset mid-sequence: bypass still visible, state zero afterwards
    idle(); reset = 1; we1 = 1; wa1 = 3; wd1 = 'hBEEF; iss_en = 1; iss_a = 5; ra2 = 3;
    #4; chk("rst_byp", rd2, 'hBEEF);
    tick();
    idle(); ra1 = 12; ra2 = 3;
    #4; cmp_model();
    chk("post_rst_cnt", pend_cnt, 0); chk("post_rst_busy", busy1, 0); chk("post_rst_rd", rd2, 0);
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset  = ($urandom_range(0, 99) == 0);
      we0    = $urandom_range(0, 1) == 1;
      we1    = $urandom_range(0, 2) == 0;
      iss_en = $urandom_range(0, 1) == 1;
      wa0    = rnd_addr();
      wa1    = rnd_addr();
      iss_a  = rnd_addr();
      ra1    = rnd_addr();
      ra2    = rnd_addr();
      wd0    = $urandom;
      wd1    = $urandom;
      #4; cmp_model();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
